branch_predictor: RTL and testbench

Dynamic branch direction predictor feeding the IF stage.
- Looks up a table of 2-bit saturating counters with the fetch PC and drives the `prediction` bit that travels down the pipe to the EX-stage branch resolution logic.
- Trains that table from the EX-stage resolution result: actual condition flag plus the 2-bit correct/mispredict code.
- Keeps saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_predictor_pkg.sv | 22 ++
 rtl/branch_predictor_sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 132 +++++++++++++
 tb/tb_branch_predictor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch direction predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - EX-stage resolution codes carried on upd_correct
//   - table-initialisation FSM state type
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken (post-init value)
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    // Resolution codes; any code with bit 1 set means "correct".
    localparam logic [1:0] CORRECT               = 2'b10;
    localparam logic [1:0] TAKEN_NOT_SUPPOSED_TO = 2'b00;
    localparam logic [1:0] NOT_TAKEN_SUPPOSED_TO = 2'b01;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function.
// Ports:
//   cur_i   - current counter value
//   taken_i - resolved branch outcome (1 = taken)
//   next_o  - counter value after training with taken_i
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    always_comb begin
        next_o = cur_i;
        case (cur_i)
            SNT:     next_o = taken_i ? WNT : SNT;
            WNT:     next_o = taken_i ? WT  : SNT;
            WT:      next_o = taken_i ? ST  : WNT;
            default: next_o = taken_i ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor (bimodal table of 2-bit counters).
// After reset the table is swept to WNT over 2^IDX_BITS cycles (INIT); in
// RUN the table is looked up combinationally with if_pc and trained from the
// EX-stage resolution. Saturating statistics count resolved and mispredicted
// branches.
// Optional feature: define BP_GSHARE_EN to XOR a HIST_BITS global history
// register into both lookup and update indices (gshare).
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   if_pc          - fetch PC used for the lookup
//   prediction     - 1 = predict taken (forced 0 during INIT)
//   ready          - 1 once table initialisation has finished
//   upd_valid      - resolved branch present in EX
//   upd_pc         - PC of the resolving branch
//   upd_taken      - actual branch outcome
//   upd_correct    - resolution code (statistics only)
//   br_count       - resolved branches since reset (saturating)
//   mispred_count  - mispredicted branches since reset (saturating)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned DBITS     = 32,
    parameter int unsigned IDX_BITS  = 4,
    parameter int unsigned HIST_BITS = 4,
    parameter int unsigned STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     if_pc,
    output logic                 prediction,
    output logic                 ready,
    input  logic                 upd_valid,
    input  logic [DBITS-1:0]     upd_pc,
    input  logic                 upd_taken,
    input  logic [1:0]           upd_correct,
    output logic [STAT_BITS-1:0] br_count,
    output logic [STAT_BITS-1:0] mispred_count
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic [1:0]           table_q [DEPTH];
    bp_state_e            state_q;
    logic [IDX_BITS-1:0]  init_ptr_q;
    logic                 ready_q;
    logic [STAT_BITS-1:0] br_count_q, br_count_d;
    logic [STAT_BITS-1:0] mispred_count_q, mispred_count_d;

    logic [IDX_BITS-1:0]  lk_idx;
    logic [IDX_BITS-1:0]  upd_idx;
    logic [1:0]           upd_next;
    logic                 upd_en;
    logic                 mispredicted;

    // PC bits outside the index field do not take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[DBITS-1:IDX_BITS+2], if_pc[1:0],
                              upd_pc[DBITS-1:IDX_BITS+2], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    assign lk_idx  = if_pc[IDX_BITS+1:2]  ^ IDX_BITS'(ghr_q);
    assign upd_idx = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign ghr_d   = upd_en ? {ghr_q[HIST_BITS-2:0], upd_taken} : ghr_q;
`else
    localparam int unsigned unused_hist_bits = HIST_BITS;

    assign lk_idx  = if_pc[IDX_BITS+1:2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
`endif

    assign upd_en       = (state_q == RUN) && upd_valid;
    assign mispredicted = (upd_correct == TAKEN_NOT_SUPPOSED_TO) ||
                          (upd_correct == NOT_TAKEN_SUPPOSED_TO);

    sat_counter2 u_sat (
        .cur_i   (table_q[upd_idx]),
        .taken_i (upd_taken),
        .next_o  (upd_next)
    );

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_en) begin
            if (br_count_q != '1) br_count_d = br_count_q + STAT_BITS'(1);
            if (mispredicted && (mispred_count_q != '1))
                mispred_count_d = mispred_count_q + STAT_BITS'(1);
        end
    end

    // Table has no reset of its own: the INIT sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= INIT;
            init_ptr_q      <= '0;
            ready_q         <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q           <= '0;
`endif
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
`ifdef BP_GSHARE_EN
            ghr_q           <= ghr_d;
`endif
            case (state_q)
                INIT: begin
                    table_q[init_ptr_q] <= WNT;
                    init_ptr_q          <= init_ptr_q + IDX_BITS'(1);
                    if (init_ptr_q == '1) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (upd_en) table_q[upd_idx] <= upd_next;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign prediction    = (state_q == RUN) && table_q[lk_idx][1];
    assign ready         = ready_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_correct;

    logic        pred, rdy, pred4, rdy4;
    logic [15:0] brc, mpc;
    logic [3:0]  brc4, mpc4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor #(.DBITS(32), .IDX_BITS(4), .HIST_BITS(4), .STAT_BITS(16)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .prediction(pred), .ready(rdy),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_correct(upd_correct), .br_count(brc), .mispred_count(mpc)
    );

    branch_predictor #(.DBITS(32), .IDX_BITS(4), .HIST_BITS(4), .STAT_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .if_pc(if_pc), .prediction(pred4), .ready(rdy4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_correct(upd_correct), .br_count(brc4), .mispred_count(mpc4)
    );

    // Reference model: integer counters, clamped arithmetic.
    int m_tbl [16];
    int m_init_cycles;
    bit m_rdy;
    int m_br, m_mp, m_br4, m_mp4;
    int m_ghr;

    function automatic int midx(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % 16);
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_rdy && (m_tbl[midx(pc)] >= 2);
    endfunction

    task automatic model_step();
        int i;
        if (reset) begin
            m_init_cycles = 0; m_rdy = 0;
            m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0; m_ghr = 0;
        end else if (!m_rdy) begin
            m_init_cycles++;
            if (m_init_cycles == 16) begin
                m_rdy = 1;
                foreach (m_tbl[k]) m_tbl[k] = 1;
            end
        end else if (upd_valid) begin
            i = midx(upd_pc);
            if (upd_taken) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
            else           m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
            m_br  = (m_br  < 65535) ? m_br  + 1 : 65535;
            m_br4 = (m_br4 < 15)    ? m_br4 + 1 : 15;
            if (upd_correct < 2) begin
                m_mp  = (m_mp  < 65535) ? m_mp  + 1 : 65535;
                m_mp4 = (m_mp4 < 15)    ? m_mp4 + 1 : 15;
            end
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 15;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; upd_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!rdy && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [1:0] c);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_correct = c;
        tick();
        upd_valid = 1'b0;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] upd_pc;
        logic        taken;
        logic [1:0]  corr;
        logic [31:0] if_pc;
        logic        exp_pred;
        int          exp_br;
        int          exp_mp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        reset = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_correct = CORRECT;
        tick(); tick();
        reset = 1'b0;

        // Reset state and INIT duration; INIT must ignore updates.
        for (int k = 0; k < 16; k++) begin
            if_pc = 32'(k * 4); upd_valid = 1'b1; upd_pc = 32'(k * 4);
            upd_taken = 1'b1; upd_correct = TAKEN_NOT_SUPPOSED_TO;
            #1;
            chk("init_ready_low", 32'(rdy), 32'd0);
            chk("init_pred_zero", 32'(pred), 32'd0);
            tick();
        end
        upd_valid = 1'b0;
        chk("ready_after_16", 32'(rdy), 32'd1);
        chk("init_br_zero", 32'(brc), 32'd0);
        chk("init_mp_zero", 32'(mpc), 32'd0);

`ifndef BP_GSHARE_EN
        vecs[0]  = '{1'b1, 32'h40, 1'b1, 2'b10, 32'h40, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 32'h40, 1'b1, 2'b00, 32'h40, 1'b1, 1, 0};
        vecs[2]  = '{1'b1, 32'h40, 1'b1, 2'b01, 32'h40, 1'b1, 2, 1};
        vecs[3]  = '{1'b1, 32'h40, 1'b1, 2'b11, 32'h40, 1'b1, 3, 2};
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 2'b00, 32'h40, 1'b1, 4, 2};
        vecs[5]  = '{1'b1, 32'h40, 1'b0, 2'b10, 32'h40, 1'b1, 5, 3};
        vecs[6]  = '{1'b1, 32'h40, 1'b0, 2'b10, 32'h40, 1'b0, 6, 3};
        vecs[7]  = '{1'b0, 32'h40, 1'b1, 2'b00, 32'h40, 1'b0, 7, 3};
        vecs[8]  = '{1'b0, 32'h40, 1'b1, 2'b00, 32'h40, 1'b0, 7, 3};
        vecs[9]  = '{1'b1, 32'h44, 1'b1, 2'b10, 32'h44, 1'b0, 7, 3};
        vecs[10] = '{1'b0, 32'h44, 1'b0, 2'b00, 32'h44, 1'b1, 8, 3};
        for (int v = 0; v < 11; v++) begin
            upd_valid = vecs[v].valid; upd_pc = vecs[v].upd_pc;
            upd_taken = vecs[v].taken; upd_correct = vecs[v].corr;
            if_pc = vecs[v].if_pc;
            #1;
            chk($sformatf("vec%0d_pred", v), 32'(pred), 32'(vecs[v].exp_pred));
            chk($sformatf("vec%0d_br", v), 32'(brc), 32'(vecs[v].exp_br));
            chk($sformatf("vec%0d_mp", v), 32'(mpc), 32'(vecs[v].exp_mp));
            tick();
        end

        // Saturation: 20 mispredicted updates on top of 8 branches / 3 mispredicts.
        for (int k = 0; k < 20; k++) upd(32'h48, 1'($urandom), TAKEN_NOT_SUPPOSED_TO);
        chk("sat_br16", 32'(brc), 32'd28);
        chk("sat_mp16", 32'(mpc), 32'd23);
        chk("sat_br4", 32'(brc4), 32'd15);
        chk("sat_mp4", 32'(mpc4), 32'd15);
        for (int k = 0; k < 3; k++) tick();
        chk("idle_br16", 32'(brc), 32'd28);
        chk("idle_mp16", 32'(mpc), 32'd23);
        chk("idle_br4", 32'(brc4), 32'd15);

        // Train entry 0 to strong-taken, then reset.
        for (int k = 0; k < 3; k++) upd(32'h40, 1'b1, CORRECT);
        if_pc = 32'h40; #1;
        chk("trained_pred", 32'(pred), 32'd1);
`endif
        do_reset();
        chk("rst_ready_low", 32'(rdy), 32'd0);
        wait_ready("rst_init_len");
        if_pc = 32'h40; #1;
        chk("rst_entry0_pred", 32'(pred), 32'd0);
        chk("rst_br", 32'(brc), 32'd0);
        chk("rst_mp", 32'(mpc), 32'd0);

`ifdef BP_GSHARE_EN
        upd(32'h0, 1'b1, CORRECT);
        upd(32'h4, 1'b1, CORRECT);
        upd(32'h8, 1'b1, CORRECT);
        if_pc = 32'h0; #1;
        chk("gs_lookup_t7", 32'(pred), 32'd0);
        if_pc = 32'h1C; #1;
        chk("gs_lookup_t0", 32'(pred), 32'd1);
        upd(32'h4, 1'b1, CORRECT);
        if_pc = 32'h24; #1;
        chk("gs_update_t6", 32'(pred), 32'd1);
`endif

        // Reset during the 8th INIT cycle restarts the full sweep.
        do_reset();
        for (int k = 0; k < 7; k++) tick();
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_correct = TAKEN_NOT_SUPPOSED_TO;
        reset = 1'b1;
        tick();
        reset = 1'b0; upd_valid = 1'b0;
        wait_ready("midinit_len");
        chk("midinit_br", 32'(brc), 32'd0);

        // Randomised run against the reference model.
        for (int c = 0; c < 800; c++) begin
            reset       = ($urandom_range(0, 149) == 0);
            upd_valid   = 1'($urandom);
            upd_pc      = {$urandom_range(0, 255) == 0 ? 26'($urandom) : 26'd0,
                           4'($urandom_range(0, 15)), 2'($urandom)};
            upd_taken   = 1'($urandom);
            upd_correct = 2'($urandom);
            if_pc       = $urandom_range(0, 1) ? upd_pc : $urandom;
            #1;
            chk("rnd_pred", 32'(pred), 32'(m_pred(if_pc)));
            chk("rnd_ready", 32'(rdy), 32'(m_rdy));
            chk("rnd_br", 32'(brc), 32'(m_br));
            chk("rnd_mp", 32'(mpc), 32'(m_mp));
            chk("rnd_br4", 32'(brc4), 32'(m_br4));
            chk("rnd_mp4", 32'(mpc4), 32'(m_mp4));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
